// File: rtl/nto1_rr_bus_muxer_pkg.sv
// -----------------------------------------------------------------------------
// nto1_rr_bus_muxer_pkg
//
// Shared constants for the N-to-1 round-robin bus muxer:
//   - FSM state encodings (IDLE waits for a candidate, HOLD keeps the captured
//     word until the consumer takes it)
//   - mode encodings for the `mode` input
// -----------------------------------------------------------------------------
package nto1_rr_bus_muxer_pkg;

  // FSM state encodings.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Selection modes driven on the `mode` input.
  localparam logic [0:0] MODE_FIXED = 1'b0;
  localparam logic [0:0] MODE_RR    = 1'b1;

endpackage : nto1_rr_bus_muxer_pkg

// File: rtl/nto1_rr_bus_muxer_bn_onehot_decoder.sv
// -----------------------------------------------------------------------------
// bn_onehot_decoder
//
// Decodes a binary channel index into a one-hot N-bit vector. An index that
// does not name a channel (idx >= N, only reachable when N is not a power of
// two) decodes to all zeros, which the muxer reads as "no channel".
//
// Ports:
//   idx     input  BW  binary channel index
//   onehot  output N   one-hot decode of idx, all zeros when idx >= N
// -----------------------------------------------------------------------------
module bn_onehot_decoder #(
  parameter int N  = 4,
  parameter int BW = 2
) (
  input  logic [BW-1:0] idx,
  output logic [N-1:0]  onehot
);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == BW'(i)) onehot[i] = 1'b1;
    end
  end

endmodule : bn_onehot_decoder

// File: rtl/nto1_rr_bus_muxer.sv
// -----------------------------------------------------------------------------
// nto1_rr_bus_muxer
//
// N-to-1 decoded multiplexer in front of a shared tristate bus. In IDLE it
// picks one requesting channel, either the channel named by `b` (fixed mode)
// or the next requester after the last grant (round-robin mode), captures its
// word into z, pulses ack for that channel and moves to HOLD. HOLD keeps z and
// sel frozen until the consumer asserts z_ready. The captured word is driven
// onto `bus` while it is valid and bus_en is high.
//
// Ports:
//   clock    input   1     system clock, rising-edge active
//   reset    input   1     synchronous, active-high reset
//   x        input   N*W   packed channel data, channel i at x[i*W +: W]
//   req      input   N     per-channel request, held until the source sees ack
//   b        input   BW    channel command, used in fixed mode only
//   mode     input   1     0 = fixed (channel b), 1 = round-robin
//   ack      output  N     one-hot, single-cycle grant acknowledge
//   sel      output  N     one-hot, channel of the current or last grant
//   z        output  W     captured data word
//   z_valid  output  1     z holds an undelivered word
//   z_ready  input   1     consumer accepts z
//   bus_en   input   1     enables the tristate bus driver
//   bus      inout   W     carries z when z_valid & bus_en, otherwise Z
// -----------------------------------------------------------------------------
module nto1_rr_bus_muxer
  import nto1_rr_bus_muxer_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int BW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N*W-1:0]  x,
  input  logic [N-1:0]    req,
  input  logic [BW-1:0]   b,
  input  logic            mode,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    sel,
  output logic [W-1:0]    z,
  output logic            z_valid,
  input  logic            z_ready,
  input  logic            bus_en,
  inout  wire  [W-1:0]    bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q,   state_d;
  logic [W-1:0]  z_q,       z_d;
  logic          z_valid_q, z_valid_d;
  logic [N-1:0]  sel_q,     sel_d;
  logic [N-1:0]  ack_q,     ack_d;
  logic [BW-1:0] last_q,    last_d;

  // ---------------------------------------------------------------------------
  // Candidate selection (only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic [N-1:0]  fixed_oh;
  logic          fixed_valid;
  logic          rr_valid;
  logic [BW-1:0] rr_idx;
  logic          cand_valid;
  logic [BW-1:0] cand_idx;
  logic [N-1:0]  cand_oh;
  logic [W-1:0]  cand_data;

  // Fixed mode: b decodes to zeros when it names no channel, so an
  // out-of-range command simply never matches a request.
  bn_onehot_decoder #(
    .N  (N),
    .BW (BW)
  ) u_fixed_dec (
    .idx    (b),
    .onehot (fixed_oh)
  );

  assign fixed_valid = |(fixed_oh & req);

  // Round-robin: scan last+1, last+2, ... wrapping at N; the first requester
  // wins. last itself is visited last, so a lone requester can be re-granted.
  always_comb begin : rr_scan
    int j;
    j        = 0;
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_q) + k) % N;
      if (!rr_valid && req[j]) begin
        rr_valid = 1'b1;
        rr_idx   = BW'(j);
      end
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      cand_valid = rr_valid;
      cand_idx   = rr_idx;
    end else begin
      cand_valid = fixed_valid;
      cand_idx   = b;
    end
  end

  // The same decoder drives sel/ack and the AND-OR data mux below.
  bn_onehot_decoder #(
    .N  (N),
    .BW (BW)
  ) u_cand_dec (
    .idx    (cand_idx),
    .onehot (cand_oh)
  );

  // Decoded AND-OR mux: at most one cand_oh bit is set.
  always_comb begin
    cand_data = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_oh[i]) cand_data = cand_data | x[i*W +: W];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    z_valid_d = z_valid_q;
    sel_d     = sel_q;
    last_d    = last_q;
    // ack is a pulse: it falls back to zero unless a grant happens this cycle.
    ack_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          z_d       = cand_data;
          sel_d     = cand_oh;
          ack_d     = cand_oh;
          last_d    = cand_idx;
          z_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // x, req, b and mode are ignored here; a mode change lands in the
        // next IDLE.
        if (z_ready) begin
          z_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      sel_q     <= '0;
      ack_q     <= '0;
      // Pointing at N-1 makes the first round-robin scan start at channel 0.
      last_q    <= BW'(N - 1);
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ack     = ack_q;
  assign sel     = sel_q;
  assign z       = z_q;
  assign z_valid = z_valid_q;

  // Bus driver only; the block never samples bus.
  assign bus = (z_valid_q && bus_en) ? z_q : {W{1'bz}};

endmodule : nto1_rr_bus_muxer

// File: tb/tb_nto1_rr_bus_muxer.sv
// -----------------------------------------------------------------------------
// tb_nto1_rr_bus_muxer
//
// Directed bench for nto1_rr_bus_muxer. u4 is the default N=4, W=8 instance;
// u3 is an N=3 instance used for the out-of-range command case. Both buses are
// tri1 nets, so a released bus reads back as all ones.
// -----------------------------------------------------------------------------
module tb_nto1_rr_bus_muxer;

  logic        clock;
  logic        reset;

  // N=4 instance signals
  logic [31:0] x4;
  logic [3:0]  req4;
  logic [1:0]  b4;
  logic        mode4;
  logic [3:0]  ack4;
  logic [3:0]  sel4;
  logic [7:0]  z4;
  logic        z_valid4;
  logic        z_ready4;
  logic        bus_en4;
  tri1  [7:0]  bus4;

  // N=3 instance signals
  logic [23:0] x3;
  logic [2:0]  req3;
  logic [1:0]  b3;
  logic        mode3;
  logic [2:0]  ack3;
  logic [2:0]  sel3;
  logic [7:0]  z3;
  logic        z_valid3;
  logic        z_ready3;
  logic        bus_en3;
  tri1  [7:0]  bus3;

  int vectors;
  int miscompares;

  nto1_rr_bus_muxer #(.N(4), .W(8)) u4 (
    .clock   (clock),
    .reset   (reset),
    .x       (x4),
    .req     (req4),
    .b       (b4),
    .mode    (mode4),
    .ack     (ack4),
    .sel     (sel4),
    .z       (z4),
    .z_valid (z_valid4),
    .z_ready (z_ready4),
    .bus_en  (bus_en4),
    .bus     (bus4)
  );

  nto1_rr_bus_muxer #(.N(3), .W(8)) u3 (
    .clock   (clock),
    .reset   (reset),
    .x       (x3),
    .req     (req3),
    .b       (b3),
    .mode    (mode3),
    .ack     (ack3),
    .sel     (sel3),
    .z       (z3),
    .z_valid (z_valid3),
    .z_ready (z_ready3),
    .bus_en  (bus_en3),
    .bus     (bus3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; x4 = 32'h44332211; req4 = 4'b1111; b4 = 2'd0; mode4 = 1'b1;
    z_ready4 = 1'b1; bus_en4 = 1'b1;
    x3 = 24'hC0B0A0; req3 = 3'b000; b3 = 2'd0; mode3 = 1'b0;
    z_ready3 = 1'b1; bus_en3 = 1'b1;
    tick();
    tick();
    vectors++; if (z4 !== 8'h00) begin miscompares++; $display("FAIL reset_z: got %h want %h", z4, 8'h00); end
    vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_z_valid: got %b want 0", z_valid4); end
    vectors++; if (ack4 !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", ack4); end
    vectors++; if (sel4 !== 4'b0000) begin miscompares++; $display("FAIL reset_sel: got %b want 0000", sel4); end
    vectors++; if (bus4 !== 8'hFF) begin miscompares++; $display("FAIL reset_bus_released: got %h want ff (pulled)", bus4); end
    vectors++; if (z_valid3 !== 1'b0) begin miscompares++; $display("FAIL reset_z_valid_n3: got %b want 0", z_valid3); end
    // First rr grant after reset goes to channel 0.
    reset = 1'b0;
    tick();
    vectors++; if (ack4 !== 4'b0001) begin miscompares++; $display("FAIL reset_first_rr_ack: got %b want 0001", ack4); end
    vectors++; if (sel4 !== 4'b0001) begin miscompares++; $display("FAIL reset_first_rr_sel: got %b want 0001", sel4); end
    vectors++; if (z4 !== 8'h11) begin miscompares++; $display("FAIL reset_first_rr_z: got %h want 11", z4); end
    vectors++; if (bus4 !== 8'h11) begin miscompares++; $display("FAIL reset_first_rr_bus: got %h want 11", bus4); end
    req4 = 4'b0000;
    tick();
    vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_drain_z_valid: got %b want 0", z_valid4); end
    vectors++; if (ack4 !== 4'b0000) begin miscompares++; $display("FAIL reset_drain_ack: got %b want 0000", ack4); end
  endtask

  task automatic test_fixed();
    mode4 = 1'b0; b4 = 2'd2; req4 = 4'b0100; x4 = 32'h44A52211; z_ready4 = 1'b1;
    tick();
    vectors++; if (z4 !== 8'hA5) begin miscompares++; $display("FAIL fixed_z: got %h want a5", z4); end
    vectors++; if (z_valid4 !== 1'b1) begin miscompares++; $display("FAIL fixed_z_valid: got %b want 1", z_valid4); end
    vectors++; if (ack4 !== 4'b0100) begin miscompares++; $display("FAIL fixed_ack: got %b want 0100", ack4); end
    vectors++; if (sel4 !== 4'b0100) begin miscompares++; $display("FAIL fixed_sel: got %b want 0100", sel4); end
    req4 = 4'b0000;
    tick();
    vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL fixed_z_valid_drop: got %b want 0", z_valid4); end
    vectors++; if (ack4 !== 4'b0000) begin miscompares++; $display("FAIL fixed_ack_pulse: got %b want 0000", ack4); end
    vectors++; if (sel4 !== 4'b0100) begin miscompares++; $display("FAIL fixed_sel_hold: got %b want 0100", sel4); end
  endtask

  task automatic test_no_grant();
    mode4 = 1'b0; b4 = 2'd1; req4 = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL nogrant_z_valid[%0d]: got %b want 0", i, z_valid4); end
      vectors++; if (ack4 !== 4'b0000) begin miscompares++; $display("FAIL nogrant_ack[%0d]: got %b want 0000", i, ack4); end
      vectors++; if (sel4 !== 4'b0100) begin miscompares++; $display("FAIL nogrant_sel[%0d]: got %b want 0100", i, sel4); end
    end
    // N=3: b=3 names no channel, so all-high requests still get no grant.
    mode3 = 1'b0; b3 = 2'b11; req3 = 3'b111;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (z_valid3 !== 1'b0) begin miscompares++; $display("FAIL nogrant_n3_z_valid[%0d]: got %b want 0", i, z_valid3); end
      vectors++; if (ack3 !== 3'b000) begin miscompares++; $display("FAIL nogrant_n3_ack[%0d]: got %b want 000", i, ack3); end
    end
    // In-range command on the same instance does grant.
    b3 = 2'd2;
    tick();
    vectors++; if (ack3 !== 3'b100) begin miscompares++; $display("FAIL n3_fixed_ack: got %b want 100", ack3); end
    vectors++; if (z3 !== 8'hC0) begin miscompares++; $display("FAIL n3_fixed_z: got %h want c0", z3); end
    req3 = 3'b000;
    tick();
    vectors++; if (z_valid3 !== 1'b0) begin miscompares++; $display("FAIL n3_drain_z_valid: got %b want 0", z_valid3); end
  endtask

  task automatic test_rr_fairness();
    logic [3:0] exp_ack [5];
    logic [7:0] exp_z   [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_z   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    x4 = 32'h44332211;
    reset = 1'b1;
    tick();
    reset = 1'b0; mode4 = 1'b1; req4 = 4'b1111; z_ready4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++; if (ack4 !== exp_ack[k]) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ack4, exp_ack[k]); end
      vectors++; if (z4 !== exp_z[k]) begin miscompares++; $display("FAIL rr_z[%0d]: got %h want %h", k, z4, exp_z[k]); end
      vectors++; if (z_valid4 !== 1'b1) begin miscompares++; $display("FAIL rr_z_valid[%0d]: got %b want 1", k, z_valid4); end
      if (k == 4) req4 = 4'b0000;
      tick();
      vectors++; if (ack4 !== 4'b0000) begin miscompares++; $display("FAIL rr_ack_low[%0d]: got %b want 0000", k, ack4); end
      vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL rr_bubble[%0d]: got %b want 0", k, z_valid4); end
    end
  endtask

  task automatic test_backpressure_bus();
    mode4 = 1'b0; b4 = 2'd0; req4 = 4'b0001; x4 = 32'h4433223C; z_ready4 = 1'b1; bus_en4 = 1'b1;
    tick();
    vectors++; if (z4 !== 8'h3C) begin miscompares++; $display("FAIL bp_grant_z: got %h want 3c", z4); end
    // Everything below is ignored while in HOLD, including the mode change.
    z_ready4 = 1'b0; x4 = 32'h443322FF; req4 = 4'b1111; mode4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_en4 = (i % 2 == 0);
      #1;
      vectors++; if (bus4 !== ((i % 2 == 0) ? 8'h3C : 8'hFF)) begin miscompares++; $display("FAIL bp_bus[%0d]: got %h want %h", i, bus4, ((i % 2 == 0) ? 8'h3C : 8'hFF)); end
      tick();
      vectors++; if (z4 !== 8'h3C) begin miscompares++; $display("FAIL bp_z[%0d]: got %h want 3c", i, z4); end
      vectors++; if (z_valid4 !== 1'b1) begin miscompares++; $display("FAIL bp_z_valid[%0d]: got %b want 1", i, z_valid4); end
      vectors++; if (ack4 !== 4'b0000) begin miscompares++; $display("FAIL bp_ack[%0d]: got %b want 0000", i, ack4); end
      vectors++; if (sel4 !== 4'b0001) begin miscompares++; $display("FAIL bp_sel[%0d]: got %b want 0001", i, sel4); end
    end
    bus_en4 = 1'b1; z_ready4 = 1'b1;
    tick();
    vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL bp_release_z_valid: got %b want 0", z_valid4); end
    vectors++; if (bus4 !== 8'hFF) begin miscompares++; $display("FAIL bp_release_bus: got %h want ff (pulled)", bus4); end
    // Mode switched to rr during HOLD: rr scan from last=0 picks channel 1.
    tick();
    vectors++; if (ack4 !== 4'b0010) begin miscompares++; $display("FAIL mode_change_ack: got %b want 0010", ack4); end
    vectors++; if (z4 !== 8'h22) begin miscompares++; $display("FAIL mode_change_z: got %h want 22", z4); end
    req4 = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    mode4 = 1'b0; b4 = 2'd3; req4 = 4'b1000; x4 = 32'h5A33223C; z_ready4 = 1'b1; bus_en4 = 1'b1;
    tick();
    req4 = 4'b0000; z_ready4 = 1'b0;
    tick();
    vectors++; if (z4 !== 8'h5A || z_valid4 !== 1'b1) begin miscompares++; $display("FAIL midhold_pre: got z=%h v=%b want z=5a v=1", z4, z_valid4); end
    reset = 1'b1;
    tick();
    vectors++; if (z4 !== 8'h00) begin miscompares++; $display("FAIL midhold_z: got %h want 00", z4); end
    vectors++; if (z_valid4 !== 1'b0) begin miscompares++; $display("FAIL midhold_z_valid: got %b want 0", z_valid4); end
    vectors++; if (sel4 !== 4'b0000) begin miscompares++; $display("FAIL midhold_sel: got %b want 0000", sel4); end
    vectors++; if (bus4 !== 8'hFF) begin miscompares++; $display("FAIL midhold_bus: got %h want ff (pulled)", bus4); end
    reset = 1'b0; mode4 = 1'b1; req4 = 4'b1111; z_ready4 = 1'b1;
    tick();
    vectors++; if (ack4 !== 4'b0001) begin miscompares++; $display("FAIL midhold_rr_restart_ack: got %b want 0001", ack4); end
    vectors++; if (z4 !== 8'h3C) begin miscompares++; $display("FAIL midhold_rr_restart_z: got %h want 3c", z4); end
    req4 = 4'b0000;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fixed();
    test_no_grant();
    test_rr_fairness();
    test_backpressure_bus();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule : tb_nto1_rr_bus_muxer
